// File: rtl/full_st0_phase_sched_pkg.sv
// Shared types for the stage-0 phase scheduler: phase state encoding and width defaults.
package full_st0_phase_sched_pkg;

    localparam int DW_LEN_DEF  = 3;
    localparam int EPOCH_W_DEF = 8;
    localparam int WDOG_W_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_ERR  = 3'd2,
        ST_TAP  = 3'd3,
        ST_DONE = 3'd4
    } phase_state_t;

    // True in the phases that consume controller events.
    function automatic logic in_phase(input phase_state_t s);
        return (s == ST_FWD) || (s == ST_ERR) || (s == ST_TAP);
    endfunction

endpackage

// File: rtl/full_st0_phase_sched_if.sv
// Job-start handshake and job configuration between the layer top and the phase scheduler.
interface full_st0_phase_sched_if
    import full_st0_phase_sched_pkg::*;
#(
    parameter int DW_LEN  = DW_LEN_DEF,
    parameter int EPOCH_W = EPOCH_W_DEF
);
    logic               start_vld;
    logic               start_rdy;
    logic [DW_LEN-1:0]  cfg_length;
    logic [DW_LEN-1:0]  cfg_depth;
    logic               cfg_state_length;
    logic [EPOCH_W-1:0] cfg_epochs;

    modport master (
        output start_vld, cfg_length, cfg_depth, cfg_state_length, cfg_epochs,
        input  start_rdy
    );

    modport slave (
        input  start_vld, cfg_length, cfg_depth, cfg_state_length, cfg_epochs,
        output start_rdy
    );
endinterface

// File: rtl/full_st0_event_counter.sv
// Clearable event counter; hit flags the event that lands on the terminal count.
module full_st0_event_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic         hit
);
    logic [W-1:0] count_reg;

    assign hit = inc && (count_reg == terminal);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + W'(1);
        end
    end
endmodule

// File: rtl/full_st0_phase_sched.sv
// Epoch/phase scheduler (FWD -> ERR -> TAP per epoch) for the stage-0 FIFO controller.
// Optional watchdog enabled by defining FULL_ST0_SCHED_WDOG_EN.
module full_st0_phase_sched
    import full_st0_phase_sched_pkg::*;
#(
    parameter int DW_LEN  = DW_LEN_DEF,
    parameter int EPOCH_W = EPOCH_W_DEF
`ifdef FULL_ST0_SCHED_WDOG_EN
    , parameter int WDOG_W = WDOG_W_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    full_st0_phase_sched_if.slave start_if,
    input  logic                 abort,
    input  logic                 state_finish,
    input  logic                 err_finish_i,
    output logic [DW_LEN-1:0]    load_length,
    output logic [DW_LEN-1:0]    load_depth,
    output logic                 state_length,
    output logic                 error_update_mode,
    output logic                 error_update_latch,
    output logic                 error_update_first,
    output logic                 error_tap_update_out,
    output logic                 error_finish_tap,
    output logic [EPOCH_W-1:0]   epoch_count,
    output logic                 busy,
    output logic                 done,
    output logic                 wdog_err
);
    phase_state_t       state_reg, state_next;
    logic [DW_LEN-1:0]  length_reg, depth_reg;
    logic               state_length_reg;
    logic [EPOCH_W-1:0] epochs_reg, epoch_count_reg;
    logic               mode_reg, latch_reg, first_reg, tap_reg, finish_tap_reg, done_reg;

    logic               accept, kill;
    logic               fwd_evt, err_evt, tap_evt, cnt_inc, cnt_hit;
    logic [EPOCH_W:0]   epoch_inc, epoch_target;
    logic               epoch_last;
    logic [EPOCH_W-1:0] epoch_sat;

    // Only events belonging to the current phase are counted.
    assign fwd_evt = (state_reg == ST_FWD) && state_finish;
    assign err_evt = (state_reg == ST_ERR) && state_finish;
    assign tap_evt = (state_reg == ST_TAP) && err_finish_i;
    assign cnt_inc = fwd_evt || err_evt || tap_evt;

    full_st0_event_counter #(.W(DW_LEN + 1)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept || kill || cnt_hit),
        .inc      (cnt_inc && !kill),
        .terminal ({1'b0, depth_reg}),
        .hit      (cnt_hit)
    );

    // One extra bit so a saturated count still compares as "last epoch".
    assign epoch_inc    = {1'b0, epoch_count_reg} + (EPOCH_W + 1)'(1);
    assign epoch_target = (epochs_reg == '0) ? (EPOCH_W + 1)'(1) : {1'b0, epochs_reg};
    assign epoch_last   = (epoch_inc >= epoch_target);
    assign epoch_sat    = (&epoch_count_reg) ? epoch_count_reg : epoch_inc[EPOCH_W-1:0];

`ifdef FULL_ST0_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_reg, wdog_next;
    logic              wdog_expire, wdog_err_reg;

    assign wdog_expire = in_phase(state_reg) && (&wdog_reg);
    assign kill        = abort || wdog_expire;
    assign wdog_err    = wdog_err_reg;

    always_comb begin
        wdog_next = wdog_reg + WDOG_W'(1);
        if (!in_phase(state_reg) || cnt_inc || (state_next != state_reg)) begin
            wdog_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_reg     <= '0;
            wdog_err_reg <= 1'b0;
        end else begin
            wdog_reg <= wdog_next;
            if (accept) begin
                wdog_err_reg <= 1'b0;
            end else if (wdog_expire) begin
                wdog_err_reg <= 1'b1;
            end
        end
    end
`else
    assign kill     = abort;
    assign wdog_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: if (start_if.start_vld) begin
                accept     = 1'b1;
                state_next = ST_FWD;
            end
            ST_FWD:  if (cnt_hit) state_next = ST_ERR;
            ST_ERR:  if (cnt_hit) state_next = ST_TAP;
            ST_TAP:  if (cnt_hit) state_next = epoch_last ? ST_DONE : ST_FWD;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (kill) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            length_reg       <= '0;
            depth_reg        <= '0;
            state_length_reg <= 1'b0;
            epochs_reg       <= '0;
            epoch_count_reg  <= '0;
            mode_reg         <= 1'b0;
            latch_reg        <= 1'b0;
            first_reg        <= 1'b0;
            tap_reg          <= 1'b0;
            finish_tap_reg   <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (kill) begin
                // epoch_count deliberately holds across an abort
                length_reg       <= '0;
                depth_reg        <= '0;
                state_length_reg <= 1'b0;
                epochs_reg       <= '0;
                mode_reg         <= 1'b0;
                latch_reg        <= 1'b0;
                first_reg        <= 1'b0;
                tap_reg          <= 1'b0;
                finish_tap_reg   <= 1'b0;
                done_reg         <= 1'b0;
            end else begin
                if (accept) begin
                    length_reg       <= start_if.cfg_length;
                    depth_reg        <= start_if.cfg_depth;
                    state_length_reg <= start_if.cfg_state_length;
                    epochs_reg       <= start_if.cfg_epochs;
                    epoch_count_reg  <= '0;
                end else if ((state_reg == ST_TAP) && cnt_hit) begin
                    epoch_count_reg <= epoch_sat;
                end
                mode_reg       <= (state_next == ST_ERR);
                latch_reg      <= (state_next == ST_ERR) || (state_next == ST_TAP);
                tap_reg        <= (state_next == ST_TAP);
                first_reg      <= (state_next == ST_ERR) &&
                                  ((state_reg != ST_ERR) || (first_reg && !err_evt));
                finish_tap_reg <= tap_evt;
                done_reg       <= (state_next == ST_DONE);
            end
        end
    end

    assign start_if.start_rdy   = (state_reg == ST_IDLE);
    assign busy                 = (state_reg != ST_IDLE);
    assign done                 = done_reg;
    assign load_length          = length_reg;
    assign load_depth           = depth_reg;
    assign state_length         = state_length_reg;
    assign error_update_mode    = mode_reg;
    assign error_update_latch   = latch_reg;
    assign error_update_first   = first_reg;
    assign error_tap_update_out = tap_reg;
    assign error_finish_tap     = finish_tap_reg;
    assign epoch_count          = epoch_count_reg;
endmodule

// File: tb/tb_full_st0_phase_sched.sv
// Scoreboard bench for full_st0_phase_sched: expected pulses are queued by stimulus, popped by a monitor.
module tb_full_st0_phase_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       abort = 1'b0;
    logic       state_finish = 1'b0;
    logic       err_finish_i = 1'b0;
    logic [2:0] load_length, load_depth;
    logic       state_length, error_update_mode, error_update_latch, error_update_first;
    logic       error_tap_update_out, error_finish_tap, busy, done, wdog_err;
    logic [7:0] epoch_count;

    always #5 clk = ~clk;

    full_st0_phase_sched_if #(.DW_LEN(3), .EPOCH_W(8)) sif ();

    full_st0_phase_sched #(
        .DW_LEN(3),
        .EPOCH_W(8)
`ifdef FULL_ST0_SCHED_WDOG_EN
        , .WDOG_W(4)
`endif
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start_if             (sif.slave),
        .abort                (abort),
        .state_finish         (state_finish),
        .err_finish_i         (err_finish_i),
        .load_length          (load_length),
        .load_depth           (load_depth),
        .state_length         (state_length),
        .error_update_mode    (error_update_mode),
        .error_update_latch   (error_update_latch),
        .error_update_first   (error_update_first),
        .error_tap_update_out (error_tap_update_out),
        .error_finish_tap     (error_finish_tap),
        .epoch_count          (epoch_count),
        .busy                 (busy),
        .done                 (done),
        .wdog_err             (wdog_err)
    );

    localparam int EV_TAP  = 0;
    localparam int EV_DONE = 1;
    typedef struct {
        int kind;
        int epoch;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push(input int kind, input int epoch);
        ev_t e;
        e.kind  = kind;
        e.epoch = epoch;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sf();
        state_finish = 1'b1;
        tick();
        state_finish = 1'b0;
    endtask

    task automatic ef();
        err_finish_i = 1'b1;
        tick();
        err_finish_i = 1'b0;
    endtask

    task automatic start_job(input int len, input int depth, input int sl, input int epochs);
        sif.start_vld        = 1'b1;
        sif.cfg_length       = 3'(len);
        sif.cfg_depth        = 3'(depth);
        sif.cfg_state_length = 1'(sl);
        sif.cfg_epochs       = 8'(epochs);
        tick();
        sif.start_vld = 1'b0;
        $display("start len=%0d depth=%0d sl=%0d epochs=%0d", len, depth, sl, epochs);
    endtask

    // Full FWD/ERR/TAP epoch; queues one tap pulse per err_finish_i and a done on the last epoch.
    task automatic run_epoch(input int depth, input bit last, input int epoch_after);
        repeat (2 * (depth + 1)) sf();
        chk("tap_entered", int'(error_tap_update_out), 1);
        for (int i = 0; i <= depth; i++) begin
            push(EV_TAP, 0);
            if (last && (i == depth)) push(EV_DONE, epoch_after);
            ef();
        end
        chk("epoch_count", int'(epoch_count), epoch_after);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (error_finish_tap) begin
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != EV_TAP) begin
                    n_errors++;
                    $display("FAIL tap_pulse: got unexpected error_finish_tap required none (queue=%0d)",
                             exp_q.size());
                end else begin
                    void'(exp_q.pop_front());
                    $display("ok   tap_pulse");
                end
            end
            if (done) begin
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) begin
                    n_errors++;
                    $display("FAIL done_pulse: got unexpected done required none (queue=%0d)",
                             exp_q.size());
                end else if (exp_q[0].epoch != int'(epoch_count)) begin
                    n_errors++;
                    $display("FAIL done_epoch: got %0d expected %0d", epoch_count, exp_q[0].epoch);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                    $display("ok   done_pulse epoch=%0d", epoch_count);
                end
            end
        end
    end

    initial begin
        sif.start_vld        = 1'b0;
        sif.cfg_length       = '0;
        sif.cfg_depth        = '0;
        sif.cfg_state_length = 1'b0;
        sif.cfg_epochs       = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        chk("rst_start_rdy", int'(sif.start_rdy), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_epoch", int'(epoch_count), 0);
        chk("rst_mode", int'(error_update_mode), 0);
        chk("rst_wdog", int'(wdog_err), 0);

        // 1: single epoch, depth=1
        start_job(3, 1, 1, 1);
        chk("t1_busy", int'(busy), 1);
        chk("t1_start_rdy", int'(sif.start_rdy), 0);
        chk("t1_load_depth", int'(load_depth), 1);
        chk("t1_load_length", int'(load_length), 3);
        chk("t1_state_length", int'(state_length), 1);
        sf(); sf();
        chk("t1_mode", int'(error_update_mode), 1);
        chk("t1_first", int'(error_update_first), 1);
        chk("t1_latch", int'(error_update_latch), 1);
        sf();
        chk("t1_first_cleared", int'(error_update_first), 0);
        chk("t1_mode_held", int'(error_update_mode), 1);
        sf();
        chk("t1_tap", int'(error_tap_update_out), 1);
        chk("t1_mode_off", int'(error_update_mode), 0);
        chk("t1_latch_tap", int'(error_update_latch), 1);
        push(EV_TAP, 0); ef();
        push(EV_TAP, 0); push(EV_DONE, 1); ef();
        chk("t1_epoch", int'(epoch_count), 1);
        tick();
        chk("t1_idle", int'(busy), 0);

        // 2: three epochs, then epochs=0 runs one
        start_job(2, 0, 0, 3);
        run_epoch(0, 1'b0, 1);
        chk("t2_back_fwd_busy", int'(busy), 1);
        chk("t2_back_fwd_tap", int'(error_tap_update_out), 0);
        run_epoch(0, 1'b0, 2);
        run_epoch(0, 1'b1, 3);
        tick();
        chk("t2_idle", int'(busy), 0);
        start_job(2, 0, 0, 0);
        chk("t2_epoch_cleared", int'(epoch_count), 0);
        run_epoch(0, 1'b1, 1);
        tick();
        chk("t2_zero_idle", int'(busy), 0);

        // 3: wrong-phase events ignored
        start_job(1, 1, 0, 1);
        ef(); ef(); ef();
        chk("t3_fwd_mode", int'(error_update_mode), 0);
        sf();
        chk("t3_fwd_one_sf", int'(error_update_mode), 0);
        sf();
        chk("t3_err", int'(error_update_mode), 1);
        sf(); sf();
        sf(); sf(); sf();
        chk("t3_tap_kept", int'(error_tap_update_out), 1);
        push(EV_TAP, 0); ef();
        chk("t3_tap_after_one", int'(error_tap_update_out), 1);
        push(EV_TAP, 0); push(EV_DONE, 1); ef();
        tick();
        chk("t3_idle", int'(busy), 0);

        // 4: abort together with the terminal state_finish in ERR
        start_job(1, 1, 1, 2);
        run_epoch(1, 1'b0, 1);
        sf(); sf(); sf();
        abort        = 1'b1;
        state_finish = 1'b1;
        tick();
        abort        = 1'b0;
        state_finish = 1'b0;
        chk("t4_busy", int'(busy), 0);
        chk("t4_mode", int'(error_update_mode), 0);
        chk("t4_latch", int'(error_update_latch), 0);
        chk("t4_tap", int'(error_tap_update_out), 0);
        chk("t4_start_rdy", int'(sif.start_rdy), 1);
        chk("t4_epoch_held", int'(epoch_count), 1);
        chk("t4_depth_cleared", int'(load_depth), 0);
        tick();
        chk("t4_still_idle", int'(busy), 0);

        // 5: start with new config mid-job is ignored
        start_job(1, 2, 0, 1);
        sif.start_vld  = 1'b1;
        sif.cfg_depth  = 3'd0;
        sif.cfg_length = 3'd5;
        tick(); tick();
        sif.start_vld = 1'b0;
        chk("t5_load_depth", int'(load_depth), 2);
        chk("t5_load_length", int'(load_length), 1);
        sf(); sf();
        chk("t5_still_fwd", int'(error_update_mode), 0);
        sf();
        chk("t5_err", int'(error_update_mode), 1);
        run_epoch(2, 1'b1, 1);
        tick();
        chk("t5_idle", int'(busy), 0);

        // 6: long silence in FWD
        start_job(0, 0, 0, 1);
`ifdef FULL_ST0_SCHED_WDOG_EN
        repeat (20) tick();
        chk("t6_wdog_err", int'(wdog_err), 1);
        chk("t6_wdog_idle", int'(busy), 0);
        start_job(0, 0, 0, 1);
        chk("t6_wdog_cleared", int'(wdog_err), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        repeat (40) tick();
        chk("t6_stays_fwd", int'(busy), 1);
        chk("t6_no_wdog", int'(wdog_err), 0);
        sf(); sf();
        push(EV_TAP, 0); push(EV_DONE, 1); ef();
        tick();
`endif
        chk("t6_idle", int'(busy), 0);

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
